riscv_dmem_arbiter: RTL and testbench
=====================================

Name: riscv_dmem_arbiter

Overview:
- Shares the single core data-memory port between the load/store unit (LSU) and one auxiliary requester (AUX), e.g. a debug or page-walk engine.
- LSU requests are one-cycle pulses. A one-entry holding buffer absorbs them when the port is busy.
- Owns the port handshake, round-robin grant, response and fault routing, and back-pressure to the LSU.
- Sits between riscv_lsu / AUX and the data bus interface unit.

Parameters:
- XLEN, 64, data and address width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- lsu_req  in  1  one-cycle request pulse
- lsu_adr  in  XLEN  request address
- lsu_d  in  XLEN  write data
- lsu_we  in  1  1 = store
- lsu_size  in  3  BYTE/HWORD/WORD/DWORD
- lsu_flush  in  1  drop buffered, ungranted LSU request
- lsu_busy  out  1  buffer full; LSU must not pulse
- lsu_ack  out  1  LSU transaction complete
- lsu_q  out  XLEN  read data
- lsu_misaligned  out  1  fault, valid with lsu_ack
- lsu_page_fault  out  1  fault, valid with lsu_ack
- aux_req  in  1  level request, held until aux_ack
- aux_adr  in  XLEN  request address
- aux_d  in  XLEN  write data
- aux_we  in  1  1 = store
- aux_size  in  3  access size
- aux_ack  out  1  AUX transaction complete
- aux_q  out  XLEN  read data
- aux_err  out  1  misaligned OR page fault, valid with aux_ack
- mem_req  out  1  level request to memory
- mem_adr  out  XLEN  address
- mem_d  out  XLEN  write data
- mem_we  out  1  write enable
- mem_size  out  3  access size
- mem_ack  in  1  completion
- mem_q  in  XLEN  read data
- mem_misaligned  in  1  fault, qualified by mem_ack
- mem_page_fault  in  1  fault, qualified by mem_ack

Behaviour:
- **States:**
  - IDLE, BUSY_LSU, BUSY_AUX.
  - Exactly one transaction is outstanding at a time.
- **Arbitration point:** each rising edge where state==IDLE, or where mem_ack is high (back-to-back).
- **LSU candidate:**
  - The buffered entry if valid, else the live lsu_req.
  - Candidate address, data, we and size come from the same source.
- **AUX candidate:** aux_req high, excluding the owner that is completing this cycle.
- **Grant rule:**
  - Single candidate wins.
  - Both present: grant the one not in last_grant. last_grant resets to AUX, so LSU wins the first tie.
- **On grant:**
  - Register mem_req=1 and the winner's mem_adr/mem_d/mem_we/mem_size.
  - state <= BUSY_x; last_grant <= winner.
  - mem_req goes high the cycle after the request edge.
- **Ungranted live lsu_req:** captured into the buffer.
  - lsu_busy = buffer valid (registered).
  - lsu_req while lsu_busy is ignored; the bench flags this as a protocol violation.
- **While BUSY:**
  - mem_req and all mem_* fields are held stable until mem_ack.
  - New lsu_req pulses go to the buffer.
- **Completion (mem_ack high in cycle M):**
  - lsu_ack/aux_ack = mem_ack qualified by owner, combinational in cycle M.
  - lsu_q/aux_q = mem_q.
  - Faults are routed to the owner. aux_err = misaligned | page_fault.
  - Next edge: if no new grant, state <= IDLE and mem_req <= 0 in M+1. Otherwise mem_req stays high with the new fields.
- **Ignored mem_ack:** mem_ack in IDLE is ignored; no ack is generated.
- **AUX protocol:** AUX must drop aux_req the cycle after aux_ack. aux_req still high then is a new request.
- **lsu_flush:**
  - Clears the buffer next edge, and suppresses capture of a same-cycle lsu_req.
  - Does not cancel an in-flight BUSY_LSU transaction.
- **Reset:**
  - state=IDLE, mem_req=0, lsu_busy=0, buffer invalid, last_grant=AUX.
  - mem_adr/mem_d/mem_we/mem_size = 0; all ack/err outputs 0.
  - A transaction in flight at reset is abandoned; a later stray mem_ack is ignored.
- **Unused outputs:** lsu_q/aux_q equal mem_q unconditionally. Consumers qualify with ack.

Decomposition:
- riscv_mpsoc_pkg:
  - Add the arbiter state enum (IDLE/BUSY_LSU/BUSY_AUX) and the owner encoding (OWN_LSU/OWN_AUX).
  - Reuse the existing BYTE/HWORD/WORD/DWORD/UNDEF_SIZE.
- Sub-module riscv_dmem_req_buffer:
  - One-entry holding register (valid, adr, d, we, size).
  - Ports: push, pop, flush, full.

Test Plan:
1. **LSU load, idle port:** lsu_req at cycle 0 (adr=0x1000, we=0, size=WORD) → mem_req=1, mem_adr=0x1000 in cycle 1; mem_ack with mem_q=0xDEADBEEF in cycle 3 → lsu_ack=1, lsu_q=0xDEADBEEF in cycle 3; mem_req=0 in cycle 4.
2. **Simultaneous first requests:** lsu_req store 0x2000 and aux_req 0x3000 in cycle 0 → LSU granted (mem_adr=0x2000); ack in cycle 2 → mem_adr=0x3000 in cycle 3 with mem_req continuously high; aux_ack on the second ack.
3. **Round-robin fairness:** repeated contention from both requesters for 6 transactions → grants alternate AUX, LSU, AUX...; neither requester is granted twice consecutively while the other waits.
4. **Back-pressure:** AUX owns the port; lsu_req in cycle 1 → lsu_busy=1 from cycle 2; ack in cycle 4 → LSU granted with the buffered fields; lsu_busy=0 in cycle 5.
5. **Flush and faults:** buffered LSU request plus lsu_flush → never issued, lsu_busy drops next cycle. AUX ack with mem_page_fault=1 → aux_err=1, lsu_page_fault=0.
6. **Reset mid-transaction:** rst high while BUSY_LSU → mem_req=0, lsu_busy=0 next cycle; a subsequent mem_ack produces no lsu_ack or aux_ack.

Source files
------------

// File: rtl/riscv_mpsoc_pkg.sv
// Shared definitions for the memory-subsystem blocks:
// access sizes, arbiter states and requester encodings.
package riscv_mpsoc_pkg;

    localparam logic [2:0] BYTE       = 3'd0;
    localparam logic [2:0] HWORD      = 3'd1;
    localparam logic [2:0] WORD       = 3'd2;
    localparam logic [2:0] DWORD      = 3'd3;
    localparam logic [2:0] UNDEF_SIZE = 3'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_LSU = 2'd1,
        BUSY_AUX = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_LSU = 1'b0,
        OWN_AUX = 1'b1
    } owner_e;

endpackage

// File: rtl/riscv_dmem_req_buffer.sv
// One-entry holding register for an LSU request that
// could not be granted in the cycle it was pulsed.
module riscv_dmem_req_buffer
    import riscv_mpsoc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] adr_i,
    input  logic [XLEN-1:0] d_i,
    input  logic            we_i,
    input  logic [2:0]      size_i,
    output logic            full_o,
    output logic [XLEN-1:0] adr_o,
    output logic [XLEN-1:0] d_o,
    output logic            we_o,
    output logic [2:0]      size_o
);

    logic            valid_q;
    logic [XLEN-1:0] adr_q;
    logic [XLEN-1:0] d_q;
    logic            we_q;
    logic [2:0]      size_q;

    // Flush wins over a same-cycle push: the dropped pulse never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (push_i) begin
            valid_q <= 1'b1;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q  <= '0;
            d_q    <= '0;
            we_q   <= 1'b0;
            size_q <= BYTE;
        end else if (push_i && !flush_i) begin
            adr_q  <= adr_i;
            d_q    <= d_i;
            we_q   <= we_i;
            size_q <= size_i;
        end
    end

    assign full_o = valid_q;
    assign adr_o  = adr_q;
    assign d_o    = d_q;
    assign we_o   = we_q;
    assign size_o = size_q;

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Round-robin arbiter sharing the core data-memory port
// between the LSU (pulsed, buffered) and an AUX requester.
module riscv_dmem_arbiter
    import riscv_mpsoc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lsu_req,
    input  logic [XLEN-1:0] lsu_adr,
    input  logic [XLEN-1:0] lsu_d,
    input  logic            lsu_we,
    input  logic [2:0]      lsu_size,
    input  logic            lsu_flush,
    output logic            lsu_busy,
    output logic            lsu_ack,
    output logic [XLEN-1:0] lsu_q,
    output logic            lsu_misaligned,
    output logic            lsu_page_fault,
    input  logic            aux_req,
    input  logic [XLEN-1:0] aux_adr,
    input  logic [XLEN-1:0] aux_d,
    input  logic            aux_we,
    input  logic [2:0]      aux_size,
    output logic            aux_ack,
    output logic [XLEN-1:0] aux_q,
    output logic            aux_err,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_adr,
    output logic [XLEN-1:0] mem_d,
    output logic            mem_we,
    output logic [2:0]      mem_size,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_q,
    input  logic            mem_misaligned,
    input  logic            mem_page_fault
);

    arb_state_e      state_q, state_d;
    owner_e          last_q, last_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] adr_q, adr_d;
    logic [XLEN-1:0] dat_q, dat_d;
    logic            we_q, we_d;
    logic [2:0]      size_q, size_d;

    logic            buf_full;
    logic [XLEN-1:0] buf_adr;
    logic [XLEN-1:0] buf_dat;
    logic            buf_we;
    logic [2:0]      buf_size;

    logic            done;
    logic            arb;
    logic            lsu_cand;
    logic            aux_cand;
    logic            gnt_lsu;
    logic            gnt_aux;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] src_adr;
    logic [XLEN-1:0] src_dat;
    logic            src_we;
    logic [2:0]      src_size;

    // A stray mem_ack while idle must never complete anything.
    assign done = mem_ack && (state_q != IDLE);
    assign arb  = (state_q == IDLE) || done;

    assign lsu_cand = buf_full ? !lsu_flush : lsu_req;
    assign aux_cand = aux_req && !(done && state_q == BUSY_AUX);

    always_comb begin
        gnt_lsu = 1'b0;
        gnt_aux = 1'b0;
        if (arb) begin
            if (lsu_cand && aux_cand) begin
                gnt_lsu = (last_q == OWN_AUX);
                gnt_aux = (last_q == OWN_LSU);
            end else begin
                gnt_lsu = lsu_cand;
                gnt_aux = aux_cand;
            end
        end
    end

    assign src_adr  = buf_full ? buf_adr  : lsu_adr;
    assign src_dat  = buf_full ? buf_dat  : lsu_d;
    assign src_we   = buf_full ? buf_we   : lsu_we;
    assign src_size = buf_full ? buf_size : lsu_size;

    assign push = lsu_req && !buf_full && !gnt_lsu;
    assign pop  = gnt_lsu && buf_full;

    riscv_dmem_req_buffer #(.XLEN(XLEN)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (lsu_flush),
        .adr_i   (lsu_adr),
        .d_i     (lsu_d),
        .we_i    (lsu_we),
        .size_i  (lsu_size),
        .full_o  (buf_full),
        .adr_o   (buf_adr),
        .d_o     (buf_dat),
        .we_o    (buf_we),
        .size_o  (buf_size)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        req_d   = req_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        size_d  = size_q;
        if (gnt_lsu) begin
            state_d = BUSY_LSU;
            last_d  = OWN_LSU;
            req_d   = 1'b1;
            adr_d   = src_adr;
            dat_d   = src_dat;
            we_d    = src_we;
            size_d  = src_size;
        end else if (gnt_aux) begin
            state_d = BUSY_AUX;
            last_d  = OWN_AUX;
            req_d   = 1'b1;
            adr_d   = aux_adr;
            dat_d   = aux_d;
            we_d    = aux_we;
            size_d  = aux_size;
        end else if (done) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= OWN_AUX;
            req_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= BYTE;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            req_q   <= req_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            size_q  <= size_d;
        end
    end

    assign lsu_ack        = mem_ack && (state_q == BUSY_LSU);
    assign aux_ack        = mem_ack && (state_q == BUSY_AUX);
    assign lsu_misaligned = lsu_ack && mem_misaligned;
    assign lsu_page_fault = lsu_ack && mem_page_fault;
    assign aux_err        = aux_ack && (mem_misaligned || mem_page_fault);
    assign lsu_q          = mem_q;
    assign aux_q          = mem_q;
    assign lsu_busy       = buf_full;

    assign mem_req  = req_q;
    assign mem_adr  = adr_q;
    assign mem_d    = dat_q;
    assign mem_we   = we_q;
    assign mem_size = size_q;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Directed, table-driven bench for riscv_dmem_arbiter:
// one record per clock cycle of inputs and expected outputs.
module tb_riscv_dmem_arbiter;
    import riscv_mpsoc_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            lsu_req, lsu_we, lsu_flush;
    logic [XLEN-1:0] lsu_adr, lsu_d;
    logic [2:0]      lsu_size;
    logic            lsu_busy, lsu_ack, lsu_misaligned, lsu_page_fault;
    logic [XLEN-1:0] lsu_q;
    logic            aux_req, aux_we;
    logic [XLEN-1:0] aux_adr, aux_d;
    logic [2:0]      aux_size;
    logic            aux_ack, aux_err;
    logic [XLEN-1:0] aux_q;
    logic            mem_req, mem_we;
    logic [XLEN-1:0] mem_adr, mem_d;
    logic [2:0]      mem_size;
    logic            mem_ack, mem_misaligned, mem_page_fault;
    logic [XLEN-1:0] mem_q;

    always #5 clk = ~clk;

    riscv_dmem_arbiter #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_req        (lsu_req),
        .lsu_adr        (lsu_adr),
        .lsu_d          (lsu_d),
        .lsu_we         (lsu_we),
        .lsu_size       (lsu_size),
        .lsu_flush      (lsu_flush),
        .lsu_busy       (lsu_busy),
        .lsu_ack        (lsu_ack),
        .lsu_q          (lsu_q),
        .lsu_misaligned (lsu_misaligned),
        .lsu_page_fault (lsu_page_fault),
        .aux_req        (aux_req),
        .aux_adr        (aux_adr),
        .aux_d          (aux_d),
        .aux_we         (aux_we),
        .aux_size       (aux_size),
        .aux_ack        (aux_ack),
        .aux_q          (aux_q),
        .aux_err        (aux_err),
        .mem_req        (mem_req),
        .mem_adr        (mem_adr),
        .mem_d          (mem_d),
        .mem_we         (mem_we),
        .mem_size       (mem_size),
        .mem_ack        (mem_ack),
        .mem_q          (mem_q),
        .mem_misaligned (mem_misaligned),
        .mem_page_fault (mem_page_fault)
    );

    typedef struct {
        bit             rs, lr, lw, lf, ar, mk, pf, ms;
        logic [XLEN-1:0] la, aa, mq;
        bit             er, ew, eb, el, ex, ee, elp, elm;
        logic [XLEN-1:0] ea;
        logic [2:0]     es;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   errors = 0;

    // Inputs: rst lsu_req lsu_adr lsu_we flush aux_req aux_adr ack q pf mis
    // Expect: mem_req adr we size busy lsu_ack aux_ack aux_err lsu_pf lsu_mis
    task automatic r(
        input bit rs, lr, input logic [XLEN-1:0] la,
        input bit lw, lf, ar, input logic [XLEN-1:0] aa,
        input bit mk, input logic [XLEN-1:0] mq, input bit pf, ms,
        input bit er, input logic [XLEN-1:0] ea, input bit ew,
        input logic [2:0] es, input bit eb, el, ex, ee, elp, elm);
        vec_t v;
        v.rs = rs; v.lr = lr; v.la = la; v.lw = lw; v.lf = lf;
        v.ar = ar; v.aa = aa; v.mk = mk; v.mq = mq; v.pf = pf;
        v.ms = ms; v.er = er; v.ea = ea; v.ew = ew; v.es = es;
        v.eb = eb; v.el = el; v.ex = ex; v.ee = ee; v.elp = elp;
        v.elm = elm;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input int row,
                       input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d got %h want %h", nm, row, act, exp);
        end
    endtask

    localparam logic [XLEN-1:0] Q0 = 64'h0123_4567_89AB_CDEF;

    initial begin
        // 1: LSU load on idle port, then a stray ack in idle
        r(0,1,'h1000,0,0, 0,0, 0,Q0,0,0,  0,0,0,WORD,      0,0,0,0,0,0);
        r(0,0,0,0,0,      0,0, 0,Q0,0,0,  1,'h1000,0,WORD, 0,0,0,0,0,0);
        r(0,0,0,0,0,      0,0, 0,Q0,0,0,  1,'h1000,0,WORD, 0,0,0,0,0,0);
        r(0,0,0,0,0,      0,0, 1,'hDEADBEEF,0,0,
          1,'h1000,0,WORD, 0,1,0,0,0,0);
        r(0,0,0,0,0,      0,0, 0,Q0,0,0,  0,0,0,WORD,      0,0,0,0,0,0);
        r(0,0,0,0,0,      0,0, 1,Q0,0,0,  0,0,0,WORD,      0,0,0,0,0,0);
        r(1,0,0,0,0,      0,0, 0,Q0,0,0,  0,0,0,WORD,      0,0,0,0,0,0);
        // 2: simultaneous first requests, LSU wins the first tie
        r(0,1,'h2000,1,0, 1,'h3000, 0,Q0,0,0, 0,0,0,WORD,  0,0,0,0,0,0);
        r(0,0,0,0,0, 1,'h3000, 0,Q0,0,0, 1,'h2000,1,WORD,  0,0,0,0,0,0);
        r(0,0,0,0,0, 1,'h3000, 1,'h55,0,0, 1,'h2000,1,WORD, 0,1,0,0,0,0);
        r(0,0,0,0,0, 1,'h3000, 0,Q0,0,0, 1,'h3000,1,DWORD, 0,0,0,0,0,0);
        r(0,0,0,0,0, 1,'h3000, 1,'h66,1,0, 1,'h3000,1,DWORD, 0,0,1,1,0,0);
        r(0,0,0,0,0, 0,0,      0,Q0,0,0, 0,0,0,WORD,        0,0,0,0,0,0);
        // 4: back-pressure while AUX owns the port
        r(0,0,0,0,0, 1,'h4000, 0,Q0,0,0, 0,0,0,WORD,        0,0,0,0,0,0);
        r(0,1,'h5000,0,0, 1,'h4000, 0,Q0,0,0,
          1,'h4000,1,DWORD, 0,0,0,0,0,0);
        r(0,0,0,0,0, 1,'h4000, 0,Q0,0,0, 1,'h4000,1,DWORD, 1,0,0,0,0,0);
        r(0,0,0,0,0, 1,'h4000, 1,'h77,0,0,
          1,'h4000,1,DWORD, 1,0,1,0,0,0);
        r(0,0,0,0,0, 0,0,      0,Q0,0,0, 1,'h5000,0,WORD,  0,0,0,0,0,0);
        // 3: sustained contention, grants alternate
        r(0,0,0,0,0, 1,'h6000, 0,Q0,0,0, 1,'h5000,0,WORD,  0,0,0,0,0,0);
        r(0,1,'h7000,0,0, 1,'h6000, 0,Q0,0,0,
          1,'h5000,0,WORD, 0,0,0,0,0,0);
        r(0,0,0,0,0, 1,'h6000, 1,'h88,0,0,
          1,'h5000,0,WORD, 1,1,0,0,0,0);
        r(0,0,0,0,0, 1,'h6000, 0,Q0,0,0, 1,'h6000,1,DWORD, 1,0,0,0,0,0);
        r(0,0,0,0,0, 1,'h6000, 1,'h99,0,0,
          1,'h6000,1,DWORD, 1,0,1,0,0,0);
        r(0,0,0,0,0, 0,0,      0,Q0,0,0, 1,'h7000,0,WORD,  0,0,0,0,0,0);
        r(0,1,'h9000,0,0, 1,'h8000, 0,Q0,0,0,
          1,'h7000,0,WORD, 0,0,0,0,0,0);
        r(0,0,0,0,0, 1,'h8000, 1,'hAA,0,0,
          1,'h7000,0,WORD, 1,1,0,0,0,0);
        r(0,0,0,0,0, 1,'h8000, 0,Q0,0,0, 1,'h8000,1,DWORD, 1,0,0,0,0,0);
        r(0,0,0,0,0, 1,'h8000, 1,'hBB,0,0,
          1,'h8000,1,DWORD, 1,0,1,0,0,0);
        r(0,0,0,0,0, 0,0,      0,Q0,0,0, 1,'h9000,0,WORD,  0,0,0,0,0,0);
        r(0,0,0,0,0, 0,0,      1,'hCC,0,1,
          1,'h9000,0,WORD, 0,1,0,0,0,1);
        r(0,0,0,0,0, 0,0,      0,Q0,0,0, 0,0,0,WORD,        0,0,0,0,0,0);
        // 5: flush of a buffered entry, flush of a same-cycle pulse
        r(0,0,0,0,0, 1,'hA000, 0,Q0,0,0, 0,0,0,WORD,        0,0,0,0,0,0);
        r(0,1,'hB000,0,0, 1,'hA000, 0,Q0,0,0,
          1,'hA000,1,DWORD, 0,0,0,0,0,0);
        r(0,0,0,0,1, 1,'hA000, 0,Q0,0,0, 1,'hA000,1,DWORD, 1,0,0,0,0,0);
        r(0,0,0,0,0, 1,'hA000, 1,'hDD,0,0,
          1,'hA000,1,DWORD, 0,0,1,0,0,0);
        r(0,0,0,0,0, 0,0,      0,Q0,0,0, 0,0,0,WORD,        0,0,0,0,0,0);
        r(0,0,0,0,0, 1,'hC000, 0,Q0,0,0, 0,0,0,WORD,        0,0,0,0,0,0);
        r(0,1,'hD000,0,1, 1,'hC000, 0,Q0,0,0,
          1,'hC000,1,DWORD, 0,0,0,0,0,0);
        r(0,0,0,0,0, 1,'hC000, 0,Q0,0,0, 1,'hC000,1,DWORD, 0,0,0,0,0,0);
        r(0,0,0,0,0, 1,'hC000, 1,'hEE,0,1,
          1,'hC000,1,DWORD, 0,0,1,1,0,0);
        r(0,0,0,0,0, 0,0,      0,Q0,0,0, 0,0,0,WORD,        0,0,0,0,0,0);
        // 6: reset with a transaction in flight and the buffer full
        r(0,1,'hE000,0,0, 0,0, 0,Q0,0,0, 0,0,0,WORD,        0,0,0,0,0,0);
        r(0,1,'hF000,0,0, 0,0, 0,Q0,0,0, 1,'hE000,0,WORD,  0,0,0,0,0,0);
        r(1,0,0,0,0,      0,0, 0,Q0,0,0, 1,'hE000,0,WORD,  1,0,0,0,0,0);
        r(0,0,0,0,0,      0,0, 0,Q0,0,0, 0,0,0,WORD,        0,0,0,0,0,0);
        r(0,0,0,0,0,      0,0, 1,Q0,1,1, 0,0,0,WORD,        0,0,0,0,0,0);
        r(0,0,0,0,0,      0,0, 0,Q0,0,0, 0,0,0,WORD,        0,0,0,0,0,0);

        rst = 1'b1;
        lsu_req = 0; lsu_adr = '0; lsu_d = '0; lsu_we = 0;
        lsu_size = WORD; lsu_flush = 0;
        aux_req = 0; aux_adr = '0; aux_d = '0; aux_we = 1;
        aux_size = DWORD;
        mem_ack = 0; mem_q = '0; mem_misaligned = 0; mem_page_fault = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", -1, 64'(mem_req), 0);
        chk("rst_mem_adr", -1, mem_adr, 0);
        chk("rst_mem_d", -1, mem_d, 0);
        chk("rst_mem_we", -1, 64'(mem_we), 0);
        chk("rst_mem_size", -1, 64'(mem_size), 0);
        chk("rst_lsu_busy", -1, 64'(lsu_busy), 0);
        chk("rst_lsu_ack", -1, 64'(lsu_ack), 0);
        chk("rst_aux_ack", -1, 64'(aux_ack), 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < tv.size(); i++) begin
            rst            = tv[i].rs;
            lsu_req        = tv[i].lr;
            lsu_adr        = tv[i].la;
            lsu_d          = ~tv[i].la;
            lsu_we         = tv[i].lw;
            lsu_flush      = tv[i].lf;
            aux_req        = tv[i].ar;
            aux_adr        = tv[i].aa;
            aux_d          = ~tv[i].aa;
            mem_ack        = tv[i].mk;
            mem_q          = tv[i].mq;
            mem_page_fault = tv[i].pf;
            mem_misaligned = tv[i].ms;
            @(negedge clk);
            chk("mem_req", i, 64'(mem_req), 64'(tv[i].er));
            if (tv[i].er) begin
                chk("mem_adr", i, mem_adr, tv[i].ea);
                chk("mem_d", i, mem_d, ~tv[i].ea);
                chk("mem_we", i, 64'(mem_we), 64'(tv[i].ew));
                chk("mem_size", i, 64'(mem_size), 64'(tv[i].es));
            end
            chk("lsu_busy", i, 64'(lsu_busy), 64'(tv[i].eb));
            chk("lsu_ack", i, 64'(lsu_ack), 64'(tv[i].el));
            chk("aux_ack", i, 64'(aux_ack), 64'(tv[i].ex));
            chk("aux_err", i, 64'(aux_err), 64'(tv[i].ee));
            chk("lsu_pf", i, 64'(lsu_page_fault), 64'(tv[i].elp));
            chk("lsu_mis", i, 64'(lsu_misaligned), 64'(tv[i].elm));
            if (tv[i].el) chk("lsu_q", i, lsu_q, tv[i].mq);
            if (tv[i].ex) chk("aux_q", i, aux_q, tv[i].mq);
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
